// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the memory it feeds.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    END,
    DONE
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_SHIFT = 2;
  localparam int IMEM_DEPTH = 256;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects stream bytes MSB-first into a 32-bit instruction word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_complete
);

  assign word_complete = shift_en && (byte_cnt == 2'(WORD_BYTES - 1));

  // word is left untouched outside shifts so it stays stable through the write cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: length header, MSB-first words, done/error.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, no bytes accepted
// LEN_HI | accepting upper byte of word count
// LEN_LO | accepting lower byte of word count, range check
// DATA   | accepting instruction bytes
// WRITE  | one-cycle memory write strobe
// END    | checksum byte (when enabled) or single pass-through cycle
// DONE   | report result, return to IDLE
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_written
);

  state_t           state_q, state_d;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_word;
  logic             done_q, err_q;
  logic             xfer, start_sess, set_err, shift_en;
  logic [1:0]       byte_cnt;
  logic             word_complete;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign xfer     = byte_valid & byte_ready;
  assign len_word = LEN_W'({len_hi_q, byte_data});

  imem_word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_sess),
    .shift_en      (shift_en),
    .byte_data     (byte_data),
    .word          (wdata),
    .byte_cnt      (byte_cnt),
    .word_complete (word_complete)
  );

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    we         = 1'b0;
    start_sess = 1'b0;
    set_err    = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_sess = 1'b1;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_d = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (32'(len_word) > 32'(DEPTH)) begin
            set_err = 1'b1;
            state_d = DONE;
          end else if (len_word == '0) begin
            state_d = END;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        shift_en   = xfer;
        if (word_complete) state_d = WRITE;
      end
      WRITE: begin
        we      = 1'b1;
        state_d = (words_written + LEN_W'(1) == len_q) ? END : DATA;
      end
      END: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (xfer) begin
          set_err = (byte_data != csum_q);
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      len_hi_q      <= '0;
      len_q         <= '0;
      words_written <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_sess) begin
        words_written <= '0;
        done_q        <= 1'b0;
        err_q         <= 1'b0;
      end
      if (state_q == LEN_HI && xfer) len_hi_q <= byte_data;
      if (state_q == LEN_LO && xfer) len_q <= len_word;
      if (we) words_written <= words_written + LEN_W'(1);
      if (set_err) err_q <= 1'b1;
      if (state_q == DONE) done_q <= ~err_q;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           csum_q <= '0;
    else if (start_sess) csum_q <= '0;
    else if (shift_en)   csum_q <= csum_q ^ byte_data;
  end
`endif

  assign waddr = 32'(words_written) << ADDR_SHIFT;
  assign busy  = (state_q != IDLE) && (state_q != DONE);
  assign done  = done_q;
  assign error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, we, busy, done, error;
  logic [31:0] waddr, wdata;
  logic [15:0] words_written;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream[$];
  logic [31:0] obs_addr[$], obs_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;
  int          exp_ww;
  bit          abort;

  int          mon_k = 0;
  int          mon_n = 0;
  logic [7:0]  mon_hi = 8'h00;
  logic        pend_we = 1'b0;

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Records writes and checks that each write lands exactly one cycle after the 4th byte of a word.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      mon_k   = 0;
      pend_we = 1'b0;
    end else begin
      if (we === 1'b1) begin
        obs_addr.push_back(waddr);
        obs_data.push_back(wdata);
      end
      checks++;
      if (we !== pend_we) begin
        errors++;
        $display("FAIL we_timing: we=%b required %b at %0t", we, pend_we, $time);
      end
      pend_we = 1'b0;
      if (start === 1'b1 && busy === 1'b0) begin
        mon_k = 0;
      end else if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
        if (mon_k == 0) mon_hi = byte_data;
        if (mon_k == 1) begin
          mon_n = {16'h0, mon_hi, byte_data};
          if (mon_n > DEPTH) mon_n = 0;
        end
        if (mon_k >= 2 && mon_k < 2 + 4 * mon_n && (mon_k - 2) % 4 == 3) pend_we = 1'b1;
        mon_k++;
      end
    end
  end

  task automatic build_expected();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = {16'h0, stream[0], stream[1]};
    exp_err = 1'b0;
    exp_ww  = 0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(32'(i * 4));
        exp_data.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
        for (int j = 0; j < 4; j++) x ^= stream[2+4*i+j];
      end
      exp_ww = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (stream[2+4*n] != x) exp_err = 1'b1;
`endif
    end
    exp_done = ~exp_err;
  endtask

  task automatic make_stream(input int n, input bit bad);
    logic [7:0]  b, x, c;
    logic [15:0] n16;
    stream.delete();
    n16 = n[15:0];
    stream.push_back(n16[15:8]);
    stream.push_back(n16[7:0]);
    if (n <= DEPTH) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        x ^= b;
      end
      c = bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(c);
`endif
    end
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    if (abort) return;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    w = 0;
    while (byte_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      abort = 1'b1;
      $display("FAIL byte_ready_timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic run_session(input string name, input int mode, input bit start_mid);
    int n;
    build_expected();
    obs_addr.delete();
    obs_data.delete();
    abort = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy/done/error=%b/%b/%b required 1/0/0", name, busy, done, error);
    end
    for (int i = 0; i < stream.size(); i++) begin
      if (start_mid && i == 3) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(stream[i], gap_for(mode));
    end
    @(negedge clk);
    byte_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_timeout: busy=%b required 0", name, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d writes required %0d", name, obs_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL %s_write%0d: addr=%h data=%h required addr=%h data=%h",
                   name, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (done !== exp_done || error !== exp_err) begin
      errors++;
      $display("FAIL %s_status: done=%b error=%b required done=%b error=%b", name, done, error, exp_done, exp_err);
    end
    checks++;
    if (words_written !== 16'(exp_ww)) begin
      errors++;
      $display("FAIL %s_words_written: got %0d required %0d", name, words_written, exp_ww);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({byte_ready, we, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags: ready/we/busy/done/error=%b required 00000", name,
               {byte_ready, we, busy, done, error});
    end
    checks++;
    if (waddr !== 32'h0 || wdata !== 32'h0 || words_written !== 16'h0) begin
      errors++;
      $display("FAIL %s_values: waddr=%h wdata=%h words_written=%0d required 0/0/0",
               name, waddr, wdata, words_written);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    stream = '{8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h05};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h03);
`endif
    run_session("basic", 0, 1'b0);
  endtask

  task automatic test_gaps();
    stream = '{8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h05};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h03);
`endif
    run_session("gaps", 1, 1'b0);
  endtask

  task automatic test_overflow();
    stream = '{8'h01, 8'h01};
    run_session("overflow257", 0, 1'b0);
    make_stream($urandom_range(257, 65535), 1'b0);
    run_session("overflow_rand", 2, 1'b0);
  endtask

  task automatic test_zero_len();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
    run_session("zero_csum_ok", 0, 1'b0);
    stream = '{8'h00, 8'h00, 8'h01};
    run_session("zero_csum_bad", 0, 1'b0);
`else
    run_session("zero", 0, 1'b0);
`endif
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_session("csum_ok", 0, 1'b0);
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_session("csum_bad", 0, 1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    obs_addr.delete();
    obs_data.delete();
    abort = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], 0);
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b0;
    #1;
    check_all_zero("reset_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_addr.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_writes: got %0d writes required 1", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 32'h0 || obs_data[0] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL reset_mid_word0: addr=%h data=%h required addr=0 data=deadbeef", obs_addr[0], obs_data[0]);
      end
    end
    make_stream(3, 1'b0);
    run_session("after_reset", 2, 1'b0);
  endtask

  task automatic test_start_while_busy();
    make_stream(2, 1'b0);
    run_session("start_busy", 0, 1'b1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      make_stream($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
      run_session($sformatf("rand%0d", s), 2, 1'b0);
    end
  endtask

  task automatic test_max_depth();
    make_stream(DEPTH, 1'b0);
    run_session("max_depth", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_start_while_busy();
    test_random();
    test_max_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream from a host link and writes 32-bit instructions into the instruction-memory write port before the core runs.
- Assembles words MSB-first, issues one write per word at byte address word_index*4, and reports done or error.
- Sits between the boot/debug byte source and the instruction memory; the core is held in reset while busy is high.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; waddr bits [9:2] index the word.
- LEN_W, 16, width of the length header field.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session when idle.
- byte_valid  in  1  host presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready.
- we  out  1  one-cycle instruction-memory write strobe.
- waddr  out  32  byte address, word-aligned (bits [1:0] = 0).
- wdata  out  32  assembled instruction.
- busy  out  1  session in progress.
- done  out  1  sticky; session finished cleanly; cleared by the next start.
- error  out  1  sticky; length overflow or checksum fail; cleared by the next start.
- words_written  out  LEN_W  count of words written this session.

Behaviour:
- Reset values: byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, words_written=0, state=IDLE, byte counter=0.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words of 4 bytes each, MSB first. The first byte goes to wdata[31:24].
- States and transitions:
  - IDLE: byte_ready=0. On start go to LEN_HI, set busy=1, clear done, error, words_written and the byte counter.
  - LEN_HI / LEN_LO: byte_ready=1. Latch the length bytes.
  - After LEN_LO: if N > DEPTH, set error=1 and go to DONE with no writes. If N = 0, go to END. Otherwise go to DATA.
  - DATA: byte_ready=1. The 2-bit byte counter shifts bytes into wdata; it wraps 3->0. On the 4th byte go to WRITE.
  - WRITE: byte_ready=0. we=1 for exactly one cycle with waddr = words_written<<2 and stable wdata. words_written increments at the end of the cycle. If words_written+1 == N go to END, else go to DATA.
  - END: checksum handling (see Optional Feature). Go to DONE.
  - DONE: busy=0. done=1 unless error. Go to IDLE.
- Latency: we asserts the cycle after the 4th byte of a word is accepted. Maximum throughput is 1 word per 5 cycles.
- start while busy: ignored. byte_valid while in IDLE: ignored, no transfer.
- Bytes are never dropped: the state holds while byte_valid=0.
- Reset mid-session: immediate return to reset values. Words already written remain in memory; no partial word is written.
- Address never exceeds (DEPTH-1)*4, guaranteed by the length check.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - END accepts one extra byte (byte_ready=1), compared against the XOR of all data bytes (length bytes excluded).
  - On mismatch, set error=1 and keep done=0.
  - N=0 still expects the checksum byte; the expected value is 0x00.
- When undefined: END takes one cycle with byte_ready=0 and expects no checksum byte.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, END, DONE);
  - the constants WORD_BYTES=4 and ADDR_SHIFT=2;
  - the default DEPTH=256, shared with the instruction memory.
- One natural sub-module: imem_word_assembler (byte shift register, 2-bit counter, word_complete flag). The FSM and address counter stay in the top module.

Test Plan:
- Stream 00 02 | 20 09 00 05 | 20 0A 00 05 -> we at waddr 0x0 with wdata 0x20090005, then at 0x4 with 0x200A0005. words_written=2, done=1, error=0.
- Same stream with byte_valid low on every other cycle -> identical writes, no dropped or duplicated bytes, no we during gaps.
- Header 01 01 (N=257 > 256) -> no we, error=1, done=0, busy returns to 0.
- Header 00 00 -> no we, done=1. With IMEM_LOADER_CHECKSUM_EN: trailing byte 00 passes, trailing byte 01 sets error=1.
- Reset asserted after 2 bytes of word 1 -> all outputs 0 immediately, word 0 write already done, no write at 0x4. A fresh start then loads correctly.
- With IMEM_LOADER_CHECKSUM_EN: stream N=1, word 11 22 33 44, checksum byte 44 -> done=1. Checksum byte 45 -> error=1. The word is written at 0x0 in both cases.
